// File: rtl/complex_fu_retry_ctrl.sv
// complex_fu_retry_ctrl
//   Sequential wrapper around the combinational Complex_ALU. Takes one op from
//   issue (valid/ready), holds its operands on the ALU inputs, samples the ALU
//   result/flags, re-executes on a residue-check error up to MAX_RETRY times and
//   hands the result to writeback (valid/ready). One op in flight at a time.
//
//   Optional feature macro: COMPLEX_FU_ERR_STATS_EN adds err_count_o, a
//   saturating count of EXEC cycles that saw alu_error_i.
//
// Ports
//   clk, reset_n                      clock / async active-low reset
//   valid_i, ready_o                  issue handshake (ready_o high in IDLE only)
//   data1_i, data2_i, immd_i,
//   opcode_i, tag_i                   issued op
//   alu_data1_o .. alu_opcode_o       registered operands to the ALU
//   alu_result_i, alu_flags_i,
//   alu_error_i                       ALU outputs
//   valid_o, ready_i                  writeback handshake
//   result_o, flags_o, tag_o          registered result
//   err_count_o                       (COMPLEX_FU_ERR_STATS_EN only)
//
// state | meaning
// IDLE  | waiting for an issued op, ready_o=1
// EXEC  | ALU evaluating held operands; retry on error
// RESP  | result presented on valid_o until ready_i

`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_IMMEDIATE
`define SIZE_IMMEDIATE 16
`endif
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 6
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 4
`endif

module complex_fu_retry_ctrl #(
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned TAG_W        = 7,
  parameter int unsigned EXC_FLAG_BIT = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [`SIZE_DATA-1:0]         data1_i,
  input  logic [`SIZE_DATA-1:0]         data2_i,
  input  logic [`SIZE_IMMEDIATE-1:0]    immd_i,
  input  logic [`SIZE_OPCODE_I-1:0]     opcode_i,
  input  logic [TAG_W-1:0]              tag_i,
  output logic [`SIZE_DATA-1:0]         alu_data1_o,
  output logic [`SIZE_DATA-1:0]         alu_data2_o,
  output logic [`SIZE_IMMEDIATE-1:0]    alu_immd_o,
  output logic [`SIZE_OPCODE_I-1:0]     alu_opcode_o,
  input  logic [2*`SIZE_DATA-1:0]       alu_result_i,
  input  logic [`EXECUTION_FLAGS-1:0]   alu_flags_i,
  input  logic                          alu_error_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [2*`SIZE_DATA-1:0]       result_o,
  output logic [`EXECUTION_FLAGS-1:0]   flags_o,
  output logic [TAG_W-1:0]              tag_o
`ifdef COMPLEX_FU_ERR_STATS_EN
  ,
  output logic [15:0]                   err_count_o
`endif
);

  localparam int FW      = `EXECUTION_FLAGS;
  localparam int RETRY_W = 4;
  localparam logic [RETRY_W-1:0] MAX_R    = RETRY_W'(MAX_RETRY);
  localparam logic [FW-1:0]      EXC_MASK = FW'(1) << EXC_FLAG_BIT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                        state_q;
  logic [RETRY_W-1:0]            retry_cnt_q;
  logic                          ready_q;
  logic                          valid_q;
  logic [`SIZE_DATA-1:0]         data1_q;
  logic [`SIZE_DATA-1:0]         data2_q;
  logic [`SIZE_IMMEDIATE-1:0]    immd_q;
  logic [`SIZE_OPCODE_I-1:0]     opcode_q;
  logic [TAG_W-1:0]              tag_q;
  logic [2*`SIZE_DATA-1:0]       result_q;
  logic [FW-1:0]                 flags_q;
  logic [FW-1:0]                 exc_flags_d;

  // Flags captured when the retry budget is exhausted.
  assign exc_flags_d = alu_flags_i | EXC_MASK;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      retry_cnt_q <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
      immd_q      <= '0;
      opcode_q    <= '0;
      tag_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            data1_q     <= data1_i;
            data2_q     <= data2_i;
            immd_q      <= immd_i;
            opcode_q    <= opcode_i;
            tag_q       <= tag_i;
            retry_cnt_q <= '0;
            ready_q     <= 1'b0;
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!alu_error_i) begin
            result_q <= alu_result_i;
            flags_q  <= alu_flags_i;
            valid_q  <= 1'b1;
            state_q  <= ST_RESP;
          end else if (retry_cnt_q < MAX_R) begin
            // Operands stay put; the ALU simply re-evaluates next cycle.
            retry_cnt_q <= retry_cnt_q + 1'b1;
          end else begin
            result_q <= alu_result_i;
            flags_q  <= exc_flags_d;
            valid_q  <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Always pass through IDLE before the next accept.
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o      = ready_q;
  assign valid_o      = valid_q;
  assign alu_data1_o  = data1_q;
  assign alu_data2_o  = data2_q;
  assign alu_immd_o   = immd_q;
  assign alu_opcode_o = opcode_q;
  assign tag_o        = tag_q;
  assign result_o     = result_q;
  assign flags_o      = flags_q;

`ifdef COMPLEX_FU_ERR_STATS_EN
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == ST_EXEC && alu_error_i && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule
